// File: rtl/pll_meas_pkg.sv
// Shared constants and state encoding for the PLL phase meter and the PLL top.
package pll_meas_pkg;

  localparam int CLK_HZ      = 50_000_000;
  localparam int FREQ_MIN_HZ = 50_000;
  // Two periods of the slowest legal reference
  localparam int TIMEOUT_DEF = (CLK_HZ / FREQ_MIN_HZ) * 2;
  localparam int CTR_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WAIT_REF = 2'd2
  } meas_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-stage input conditioning plus edge register; level and single-cycle rise pulse.
// SYNC=1 marks the stages as a metastability synchronizer, SYNC=0 as plain delay matching.
module sync_edge #(
  parameter int SYNC = 1
) (
  input  logic clk_50,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic cur;
  logic prev_q;

  generate
    if (SYNC != 0) begin : g_meta
      logic [1:0] meta_q;
      always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) meta_q <= '0;
        else     meta_q <= {meta_q[0], d};
      end
      assign cur = meta_q[1];
    end else begin : g_plain
      logic dly1_q;
      logic dly2_q;
      always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
          dly1_q <= 1'b0;
          dly2_q <= 1'b0;
        end else begin
          dly1_q <= d;
          dly2_q <= dly1_q;
        end
      end
      assign cur = dly2_q;
    end
  endgenerate

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= cur;
  end

  assign level = cur;
  assign rise  = cur & ~prev_q;

endmodule

// File: rtl/pll_phase_meter.sv
// Measures reference period and ref-to-pllout rising-edge delay in clk_50 cycles,
// and derives lock (stable delay) and no-signal (reference timeout) status.
module pll_phase_meter
  import pll_meas_pkg::*;
#(
  parameter int CTR_W      = CTR_W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int LOCK_TOL   = 64,
  parameter int LOCK_COUNT = 8
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             ref_u,
  input  logic             pll_in,
  output logic [CTR_W-1:0] period,
  output logic [CTR_W-1:0] delay,
  output logic             meas_valid,
  output logic             locked,
  output logic             nosig
);

  localparam int STK_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CTR_W-1:0] CNT_MAX   = '1;
  localparam logic [CTR_W-1:0] TIMEOUT_C = CTR_W'(TIMEOUT);
  localparam logic [CTR_W:0]   TOL_C     = (CTR_W + 1)'(LOCK_TOL);
  localparam logic [STK_W-1:0] STK_MAX   = STK_W'(LOCK_COUNT);

  logic ref_lvl, ref_rise;
  logic pll_lvl, pll_rise;
  logic unused_lvl;

  sync_edge #(.SYNC(1)) u_ref_sync (
    .clk_50 (clk_50),
    .rst    (rst),
    .d      (ref_u),
    .level  (ref_lvl),
    .rise   (ref_rise)
  );

  sync_edge #(.SYNC(0)) u_pll_dly (
    .clk_50 (clk_50),
    .rst    (rst),
    .d      (pll_in),
    .level  (pll_lvl),
    .rise   (pll_rise)
  );

  assign unused_lvl = ref_lvl ^ pll_lvl;

  meas_state_t      state_q, state_d;
  logic [CTR_W-1:0] cnt_q;
  logic [CTR_W-1:0] dly_lat_q, dly_lat_d;
  logic [CTR_W-1:0] prev_dly_q, prev_dly_d;
  logic [STK_W-1:0] streak_q, streak_d;
  logic             first_q, first_d;
  logic [CTR_W-1:0] period_q, period_d;
  logic [CTR_W-1:0] delay_q, delay_d;
  logic             mv_q, mv_d;
  logic             locked_q, locked_d;
  logic             nosig_q, nosig_d;
  logic [CTR_W:0]   diff_raw, diff_abs;
  logic             stable;

  // Free-running period counter, restarted at each reference rise
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst)                 cnt_q <= '0;
    else if (ref_rise)       cnt_q <= CTR_W'(1);
    else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CTR_W'(1);
  end

  assign diff_raw = {1'b0, dly_lat_q} - {1'b0, prev_dly_q};
  assign diff_abs = diff_raw[CTR_W] ? (~diff_raw + (CTR_W + 1)'(1)) : diff_raw;
  assign stable   = (diff_abs <= TOL_C);

  always_comb begin
    state_d    = state_q;
    dly_lat_d  = dly_lat_q;
    prev_dly_d = prev_dly_q;
    streak_d   = streak_q;
    first_d    = first_q;
    period_d   = period_q;
    delay_d    = delay_q;
    mv_d       = 1'b0;
    locked_d   = locked_q;
    nosig_d    = nosig_q;

    case (state_q)
      IDLE: begin
        if (ref_rise) begin
          nosig_d = 1'b0;
          first_d = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (ref_rise) begin
          // Previous period ended without a pll edge: not a valid measurement
          streak_d = '0;
          locked_d = 1'b0;
          if (pll_rise) begin
            dly_lat_d = '0;
            state_d   = WAIT_REF;
          end
        end else if (pll_rise) begin
          dly_lat_d = cnt_q;
          state_d   = WAIT_REF;
        end else if (cnt_q >= TIMEOUT_C) begin
          nosig_d  = 1'b1;
          locked_d = 1'b0;
          streak_d = '0;
          state_d  = IDLE;
        end
      end
      WAIT_REF: begin
        if (ref_rise) begin
          period_d   = cnt_q;
          delay_d    = dly_lat_q;
          mv_d       = 1'b1;
          prev_dly_d = dly_lat_q;
          if (first_q) begin
            first_d  = 1'b0;
            streak_d = '0;
          end else if (stable) begin
            streak_d = (streak_q == STK_MAX) ? streak_q : streak_q + STK_W'(1);
          end else begin
            streak_d = '0;
          end
          locked_d = (streak_d == STK_MAX);
          if (pll_rise) begin
            dly_lat_d = '0;
            state_d   = WAIT_REF;
          end else begin
            state_d   = ARMED;
          end
        end else if (cnt_q >= TIMEOUT_C) begin
          nosig_d  = 1'b1;
          locked_d = 1'b0;
          streak_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dly_lat_q  <= '0;
      prev_dly_q <= '0;
      streak_q   <= '0;
      first_q    <= 1'b1;
      period_q   <= '0;
      delay_q    <= '0;
      mv_q       <= 1'b0;
      locked_q   <= 1'b0;
      nosig_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      dly_lat_q  <= dly_lat_d;
      prev_dly_q <= prev_dly_d;
      streak_q   <= streak_d;
      first_q    <= first_d;
      period_q   <= period_d;
      delay_q    <= delay_d;
      mv_q       <= mv_d;
      locked_q   <= locked_d;
      nosig_q    <= nosig_d;
    end
  end

  assign period     = period_q;
  assign delay      = delay_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign nosig      = nosig_q;

endmodule

// File: tb/tb_pll_phase_meter.sv
// Directed bench for pll_phase_meter: 400-cycle reference with programmable pll delay.
module tb_pll_phase_meter;

  logic        clk_50;
  logic        rst;
  logic        ref_u;
  logic        pll_in;
  logic [15:0] period;
  logic [15:0] delay;
  logic        meas_valid;
  logic        locked;
  logic        nosig;

  int n_checks = 0;
  int n_fail   = 0;

  int          mv_cnt = 0;
  logic [15:0] cap_period = '0;
  logic [15:0] cap_delay  = '0;
  logic        cap_locked = 1'b0;

  pll_phase_meter dut (
    .clk_50     (clk_50),
    .rst        (rst),
    .ref_u      (ref_u),
    .pll_in     (pll_in),
    .period     (period),
    .delay      (delay),
    .meas_valid (meas_valid),
    .locked     (locked),
    .nosig      (nosig)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  // Every high cycle of meas_valid is counted, so a stretched strobe shows up as extra counts
  always @(negedge clk_50) begin
    if (meas_valid === 1'b1) begin
      mv_cnt     <= mv_cnt + 1;
      cap_period <= period;
      cap_delay  <= delay;
      cap_locked <= locked;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  // One 400-cycle reference period, ref high for the first half, pll high for 100 cycles from dly
  task automatic run_period(input int dly, input bit pll_en);
    for (int c = 0; c < 400; c++) begin
      ref_u  = (c < 200);
      pll_in = pll_en && (c >= dly) && (c < dly + 100);
      @(negedge clk_50);
    end
  endtask

  initial begin
    rst    = 1'b1;
    ref_u  = 1'b0;
    pll_in = 1'b0;
    tick(4);
    chk("rst_period", period, 0);
    chk("rst_delay", delay, 0);
    chk("rst_mv", meas_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_nosig", nosig, 1);
    rst = 1'b0;

    tick(5000);
    chk("idle_nosig", nosig, 1);
    chk("idle_locked", locked, 0);
    chk("idle_period", period, 0);
    chk("idle_delay", delay, 0);
    chk("idle_mv_cnt", mv_cnt, 0);

    // Lock acquisition at delay 100
    run_period(100, 1'b1);
    chk("p1_mv_cnt", mv_cnt, 0);
    chk("p1_nosig", nosig, 0);
    run_period(100, 1'b1);
    chk("p2_mv_cnt", mv_cnt, 1);
    chk("p2_period", cap_period, 400);
    chk("p2_delay", cap_delay, 100);
    chk("p2_locked", cap_locked, 0);
    repeat (7) run_period(100, 1'b1);
    chk("p9_mv_cnt", mv_cnt, 8);
    chk("p9_locked", cap_locked, 0);
    run_period(100, 1'b1);
    chk("p10_mv_cnt", mv_cnt, 9);
    chk("p10_locked", cap_locked, 1);

    // Step of 100 breaks lock on the very strobe that reports it
    run_period(200, 1'b1);
    run_period(200, 1'b1);
    chk("step_delay", cap_delay, 200);
    chk("step_locked", cap_locked, 0);
    chk("step_live_locked", locked, 0);
    repeat (7) run_period(200, 1'b1);
    chk("relock7_locked", cap_locked, 0);
    run_period(200, 1'b1);
    chk("relock8_mv_cnt", mv_cnt, 19);
    chk("relock8_locked", cap_locked, 1);

    // Step of 50 stays within tolerance
    run_period(250, 1'b1);
    run_period(250, 1'b1);
    chk("small_step_delay", cap_delay, 250);
    chk("small_step_locked", cap_locked, 1);

    // Missing pll edge: the period is dropped and lock is lost
    run_period(250, 1'b0);
    chk("miss_prev_mv_cnt", mv_cnt, 22);
    chk("miss_prev_locked", cap_locked, 1);
    run_period(250, 1'b1);
    chk("miss_mv_cnt", mv_cnt, 22);
    chk("miss_locked", locked, 0);

    // Aligned pll and ref edges give zero delay
    run_period(0, 1'b1);
    run_period(0, 1'b1);
    chk("align_mv_cnt", mv_cnt, 24);
    chk("align_delay", cap_delay, 0);
    chk("align_period", cap_period, 400);
    chk("align_locked", cap_locked, 0);
    repeat (7) run_period(0, 1'b1);
    chk("align7_locked", locked, 0);
    run_period(0, 1'b1);
    chk("align8_mv_cnt", mv_cnt, 32);
    chk("align8_locked", locked, 1);

    // Reference stops: rise sampled 2.5 cycles after drive, nosig 2000 cycles after that
    tick(1602);
    chk("to_before_nosig", nosig, 0);
    chk("to_before_locked", locked, 1);
    tick(1);
    chk("to_nosig", nosig, 1);
    chk("to_locked", locked, 0);
    tick(2000);
    chk("to_mv_cnt", mv_cnt, 32);

    // Resume: first rise only clears nosig, second rise measures
    run_period(100, 1'b1);
    chk("resume_nosig", nosig, 0);
    chk("resume1_mv_cnt", mv_cnt, 32);
    run_period(100, 1'b1);
    chk("resume2_mv_cnt", mv_cnt, 33);
    chk("resume2_period", cap_period, 400);
    chk("resume2_delay", cap_delay, 100);
    chk("resume2_locked", cap_locked, 0);
    repeat (8) run_period(100, 1'b1);
    chk("resume_locked", locked, 1);

    // Reset mid-period while locked
    for (int c = 0; c < 150; c++) begin
      ref_u  = (c < 200);
      pll_in = (c >= 100);
      @(negedge clk_50);
    end
    chk("pre_rst_mv_cnt", mv_cnt, 42);
    rst    = 1'b1;
    ref_u  = 1'b0;
    pll_in = 1'b0;
    #1;
    chk("arst_period", period, 0);
    chk("arst_delay", delay, 0);
    chk("arst_mv", meas_valid, 0);
    chk("arst_locked", locked, 0);
    chk("arst_nosig", nosig, 1);
    tick(3);
    rst = 1'b0;
    tick(50);
    run_period(100, 1'b1);
    chk("postrst1_mv_cnt", mv_cnt, 42);
    chk("postrst1_nosig", nosig, 0);
    run_period(100, 1'b1);
    chk("postrst2_mv_cnt", mv_cnt, 43);
    chk("postrst2_period", cap_period, 400);
    chk("postrst2_delay", cap_delay, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
